// File: rtl/pla_scheduler_pkg.sv
// Shared types for the PLA scheduler: issue tags and tagged results.
package pla_sched_pkg;

  localparam int   PLA_ID_W       = 2;
  localparam logic PLA_FN_SIGMOID = 1'b1;
  localparam logic PLA_FN_TANH    = 1'b0;

  // Tag carried alongside each operand through the PLA.
  typedef struct packed {
    logic [PLA_ID_W-1:0] id;
    logic                func;
  } pla_tag_t;

  // Result FIFO entry: tag of the issuing requester plus the PLA result.
  typedef struct packed {
    pla_tag_t    tag;
    logic [31:0] data;
  } pla_res_t;

endpackage

// File: rtl/pla_scheduler_fifo.sv
// Show-ahead FIFO with occupancy count, used for both tags and results.
module sched_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [AW:0]      count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != (AW+1)'(DEPTH)) | do_pop);

  // Storage write; depth is a power of two so pointers wrap naturally.
  // NOTE: the storage array is deliberately not reset -- count/pointers alone
  // define which entries are valid, so clearing the data buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/pla_scheduler.sv
// Round-robin scheduler sharing one sigmoid/tanh PLA between NUM_REQ
// requesters; results come back in issue order, tagged with requester id.
module pla_scheduler
  import pla_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int RES_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_func,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic                  pla_select,
  output logic                  pla_valid_in,
  output logic                  pla_valid_in_rev,
  output logic [31:0]           pla_x,
  input  logic                  pla_valid_out,
  input  logic [31:0]           pla_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_func,
  output logic [31:0]           rsp_data,
  output logic                  busy,
  output logic                  err_orphan
);

  localparam int CNT_W = $clog2(RES_DEPTH) + 1;

  logic [31:0]     req_data_a [NUM_REQ];
  logic [ID_W-1:0] rr_q, rr_d, cand, grant_id;
  logic            grant_vld, credit_ok;
  logic            pla_valid_q, pla_select_q, err_orphan_q;
  logic [31:0]     pla_x_q;

  logic [CNT_W-1:0] tag_count, res_count;
  logic [CNT_W:0]   inflight;
  logic             tag_empty, res_empty, tag_pop, orphan;
  pla_tag_t         tag_in, tag_head;
  pla_res_t         res_in, res_head;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_data_a[k] = req_data[32*k +: 32];
  end

  // Credits come from registered counts, so a pop frees a slot next cycle.
  assign inflight  = {1'b0, tag_count} + {1'b0, res_count};
  assign credit_ok = inflight < (CNT_W+1)'(RES_DEPTH);

  // Round-robin arbiter: first valid requester at or after the rr pointer.
  // NOTE: combinational blocks use blocking '=' with every output defaulted
  // first, so the loop sees its own updates and no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = rr_q;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_q) + i) % NUM_REQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
    grant_vld = grant_vld & credit_ok;
  end

  assign req_ready = grant_vld ? (NUM_REQ'(1) << grant_id) : '0;
  assign rr_d      = grant_vld ? ID_W'((int'(grant_id) + 1) % NUM_REQ) : rr_q;

  // Issue register: one operand to the PLA the cycle after each handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q         <= '0;
      pla_valid_q  <= 1'b0;
      pla_x_q      <= '0;
      pla_select_q <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      pla_valid_q <= grant_vld;
      if (grant_vld) begin
        pla_x_q      <= req_data_a[grant_id];
        pla_select_q <= req_func[grant_id];
      end
      if (orphan) err_orphan_q <= 1'b1;
    end
  end

  assign tag_in.id   = grant_id;
  assign tag_in.func = req_func[grant_id];

  // A PLA result with no outstanding tag is dropped and flagged.
  assign tag_pop = pla_valid_out & ~tag_empty;
  assign orphan  = pla_valid_out & tag_empty;

  assign res_in.tag  = tag_head;
  assign res_in.data = pla_out;

  sched_fifo #(.WIDTH($bits(pla_tag_t)), .DEPTH(RES_DEPTH)) u_tag_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (grant_vld),
    .push_data_i (tag_in),
    .pop_i       (tag_pop),
    .head_o      (tag_head),
    .count_o     (tag_count),
    .empty_o     (tag_empty)
  );

  sched_fifo #(.WIDTH($bits(pla_res_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (tag_pop),
    .push_data_i (res_in),
    .pop_i       (rsp_valid & rsp_ready),
    .head_o      (res_head),
    .count_o     (res_count),
    .empty_o     (res_empty)
  );

  // Response fields are forced to zero when empty so stale storage never shows.
  assign rsp_valid = ~res_empty;
  assign rsp_id    = res_empty ? '0 : res_head.tag.id;
  assign rsp_func  = res_empty ? 1'b0 : res_head.tag.func;
  assign rsp_data  = res_empty ? '0 : res_head.data;

  assign pla_valid_in     = pla_valid_q;
  assign pla_valid_in_rev = pla_valid_q;
  assign pla_x            = pla_x_q;
  assign pla_select       = pla_select_q;
  assign err_orphan       = err_orphan_q;
  assign busy             = (tag_count != '0) | (res_count != '0) | pla_valid_q;

endmodule

// File: tb/tb_pla_scheduler.sv
// Self-checking bench for pla_scheduler: random traffic against a queue-based
// reference model plus a PLA model with programmable latency.
module tb_pla_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid, req_ready, req_func;
  logic [127:0] req_data;
  logic         pla_select, pla_valid_in, pla_valid_in_rev;
  logic [31:0]  pla_x;
  logic         pla_valid_out;
  logic [31:0]  pla_out = '0;
  logic         rsp_valid, rsp_ready, rsp_func, busy, err_orphan;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;

  logic model_vld  = 1'b0;
  logic orphan_vld = 1'b0;
  assign pla_valid_out = model_vld | orphan_vld;

  pla_scheduler #(.NUM_REQ(4), .ID_W(2), .RES_DEPTH(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_func         (req_func),
    .req_data         (req_data),
    .pla_select       (pla_select),
    .pla_valid_in     (pla_valid_in),
    .pla_valid_in_rev (pla_valid_in_rev),
    .pla_x            (pla_x),
    .pla_valid_out    (pla_valid_out),
    .pla_out          (pla_out),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_id           (rsp_id),
    .rsp_func         (rsp_func),
    .rsp_data         (rsp_data),
    .busy             (busy),
    .err_orphan       (err_orphan)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stand-in PLA arithmetic: any distinct function per select value will do.
  function automatic logic [31:0] pla_fn(input logic [31:0] x, input logic f);
    return f ? (x ^ 32'h5A5A_0F0F) : {x[15:0], x[31:16]};
  endfunction

  // PLA model: in-order pipe, each operand returns no earlier than pla_lat cycles.
  typedef struct { logic [31:0] y; int due; } pla_t;
  pla_t pla_q[$];
  int   pla_lat = 3;

  always @(negedge clk) begin
    model_vld = 1'b0;
    if (reset) begin
      pla_q.delete();
    end else begin
      if (pla_valid_in) pla_q.push_back('{y: pla_fn(pla_x, pla_select), due: cyc + pla_lat});
      if (pla_q.size() > 0 && pla_q[0].due <= cyc) begin
        model_vld = 1'b1;
        pla_out   = pla_q[0].y;
        void'(pla_q.pop_front());
      end
    end
  end

  // Reference model: issued-but-unpopped operands in order, how many of them
  // have come back from the PLA, the rr pointer, and the last issue.
  typedef struct { logic [1:0] id; logic func; logic [31:0] data; } exp_t;
  exp_t        iss_q[$];
  int          ret_cnt = 0;
  int          m_rr    = 0;
  logic        m_hs    = 1'b0;
  logic [31:0] m_x     = '0;
  logic        m_f     = 1'b0;
  int          dut_issues = 0;

  // One clock cycle: drive inputs at the falling edge, check, update model at the rising edge.
  task automatic cycle(input logic [3:0] v, input logic [3:0] f, input logic [127:0] d,
                       input logic rdy, input logic orph);
    int   k;
    logic exp_vld, pop, ret;
    logic [3:0] exp_rdy;
    req_valid = v; req_func = f; req_data = d; rsp_ready = rdy; orphan_vld = orph;
    #1;
    exp_vld = 1'b0; exp_rdy = '0; k = 0;
    if (iss_q.size() < 8) begin
      for (int i = 0; i < 4; i++) begin
        int c;
        c = (m_rr + i) % 4;
        if (!exp_vld && v[c]) begin exp_vld = 1'b1; k = c; end
      end
    end
    if (exp_vld) exp_rdy[k] = 1'b1;
    if (|(v & req_ready)) dut_issues++;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("pla_valid_in", 32'(pla_valid_in), 32'(m_hs));
    check("pla_valid_in_rev", 32'(pla_valid_in_rev), 32'(m_hs));
    if (m_hs) begin
      check("pla_x", pla_x, m_x);
      check("pla_select", 32'(pla_select), 32'(m_f));
    end
    check("busy", 32'(busy), 32'(iss_q.size() != 0));
    check("rsp_valid", 32'(rsp_valid), 32'(ret_cnt != 0));
    pop = rsp_valid && rdy && (ret_cnt != 0);
    if (pop) begin
      check("rsp_id", 32'(rsp_id), 32'(iss_q[0].id));
      check("rsp_func", 32'(rsp_func), 32'(iss_q[0].func));
      check("rsp_data", rsp_data, iss_q[0].data);
    end
    ret = pla_valid_out && (iss_q.size() > ret_cnt);
    @(posedge clk);
    m_hs = exp_vld;
    if (exp_vld) begin
      m_x  = d[32*k +: 32];
      m_f  = f[k];
      m_rr = (k + 1) % 4;
      iss_q.push_back('{id: 2'(k), func: f[k], data: pla_fn(d[32*k +: 32], f[k])});
    end
    if (ret) ret_cnt++;
    if (pop) begin void'(iss_q.pop_front()); ret_cnt--; end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    cycle(4'b0000, 4'b0000, '0, rdy, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && iss_q.size() != 0; i++) idle(1'b1);
    check(tag, 32'(iss_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    req_valid = '0; req_func = '0; req_data = '0; rsp_ready = 1'b0; orphan_vld = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    iss_q.delete();
    ret_cnt = 0; m_rr = 0; m_hs = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    reset = 1'b1;
    req_valid = '0; req_func = '0; req_data = '0; rsp_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_pla_valid_in", 32'(pla_valid_in), 32'd0);
    check("rst_pla_x", pla_x, 32'd0);
    check("rst_pla_select", 32'(pla_select), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_orphan", 32'(err_orphan), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    // Orphan result with nothing issued
    cycle(4'b0000, 4'b0000, '0, 1'b1, 1'b1);
    idle(1'b1);
    check("orphan_sticky", 32'(err_orphan), 32'd1);
    check("orphan_rsp_valid", 32'(rsp_valid), 32'd0);
    do_reset();
    check("orphan_cleared", 32'(err_orphan), 32'd0);

    // Single sigmoid request from requester 0
    pla_lat = 3;
    cycle(4'b0001, 4'b0001, {96'h0, 32'h3F80_0000}, 1'b1, 1'b0);
    check("single_select", 32'(pla_select), 32'd1);
    check("single_x", pla_x, 32'h3F80_0000);
    drain("single_drain");

    // All requesters valid continuously: strict rotation
    for (int i = 0; i < 24; i++) cycle(4'b1111, 4'($urandom), rnd128(), 1'b1, 1'b0);
    drain("rr_drain");

    // Backpressure: credits run out after RES_DEPTH issues
    base = dut_issues;
    for (int i = 0; i < 14; i++) cycle(4'b0001, 4'($urandom), rnd128(), 1'b0, 1'b0);
    check("bp_issue_count", 32'(dut_issues - base), 32'd8);
    for (int i = 0; i < 6; i++) cycle(4'b0001, 4'($urandom), rnd128(), 1'b1, 1'b0);
    check("bp_resumed", 32'(dut_issues - base > 8), 32'd1);
    drain("bp_drain");

    // Random traffic, short then long PLA latency
    for (int i = 0; i < 150; i++)
      cycle(4'($urandom), 4'($urandom), rnd128(), $urandom_range(0, 3) != 0, 1'b0);
    pla_lat = 7;
    for (int i = 0; i < 250; i++)
      cycle(4'($urandom), 4'($urandom), rnd128(), $urandom_range(0, 3) != 0, 1'b0);
    drain("rand_drain");
    idle(1'b1);
    check("busy_after_drain", 32'(busy), 32'd0);
    check("no_orphan_in_traffic", 32'(err_orphan), 32'd0);

    // Reset with five operands outstanding
    for (int i = 0; i < 5; i++) cycle(4'b1111, 4'($urandom), rnd128(), 1'b0, 1'b0);
    check("pre_reset_busy", 32'(busy), 32'd1);
    do_reset();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    cycle(4'b1111, 4'($urandom), rnd128(), 1'b1, 1'b0);
    drain("midrst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
